decode_ctrl_stage: RTL and testbench

//  Registered ID-stage control decoder for the 5-stage RV32 core. Decodes opcode/funct3/funct7 into the ID/EX

---
 rtl/decode_ctrl_stage.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_decode_ctrl_stage.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl_stage.sv
// -----------------------------------------------------------------------------
// decode_ctrl_stage
// Registered ID-stage control decoder for a 5-stage RV32 core. The instruction
// word is decoded into the ID/EX control bundle, which is captured in a single
// valid/ready pipeline slot. Divide/remainder operations (RV32M, when enabled)
// keep the slot occupied for MDIV_CYCLES cycles before presenting the bundle.
//
// Ports
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   in_valid/in_ready   upstream handshake (in_ready is combinational)
//   instr, pc_in        instruction word and its PC
//   flush               kills the held/incoming instruction, highest priority
//   out_valid/out_ready downstream handshake
//   pc_out              registered PC
//   rd, rs1, rs2        register specifiers
//   reg_write, mem_write, mem_to_reg, pc_branch, jalr_n  control bits
//   src_a_sel, src_b_sel, alu_op, imm_sel, str_ctrl      datapath selects
//   illegal             unrecognised opcode, or M-op with EN_M=0
//   md_busy             divide countdown in progress
// -----------------------------------------------------------------------------
module decode_ctrl_stage #(
  parameter int XLEN        = 32,
  parameter bit EN_M        = 1'b1,
  parameter int MDIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc_out,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic            reg_write,
  output logic            mem_write,
  output logic            mem_to_reg,
  output logic            pc_branch,
  output logic            jalr_n,
  output logic [1:0]      src_a_sel,
  output logic [1:0]      src_b_sel,
  output logic [4:0]      alu_op,
  output logic [2:0]      imm_sel,
  output logic [2:0]      str_ctrl,
  output logic            illegal,
  output logic            md_busy
);

  localparam int CW = $clog2(MDIV_CYCLES + 1);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'b00,
    ST_FULL   = 2'b01,
    ST_MDWAIT = 2'b10
  } state_t;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       pc_branch;
    logic       jalr_n;
    logic [1:0] src_a_sel;
    logic [1:0] src_b_sel;
    logic [4:0] alu_op;
    logic [2:0] imm_sel;
    logic [2:0] str_ctrl;
    logic       illegal;
  } ctrl_t;

  // Idle bundle: everything quiet, jalr_n inactive-high, no immediate.
  function automatic ctrl_t ctrl_reset();
    ctrl_t c;
    c         = '0;
    c.jalr_n  = 1'b1;
    c.imm_sel = 3'd6;
    return c;
  endfunction

  logic [6:0]    opcode_s;
  logic [2:0]    funct3_s;
  logic [6:0]    funct7_s;
  logic          m_op_s;
  logic          div_s;
  logic          accept_s;
  logic          in_ready_s;
  logic          load_s;
  ctrl_t         dec_s;
  ctrl_t         ctrl_r;
  state_t        state_r;
  state_t        state_next_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_next_s;
  logic [XLEN-1:0] pc_r;
  logic          out_valid_r;
  logic          md_busy_r;

  assign opcode_s = instr[6:0];
  assign funct3_s = instr[14:12];
  assign funct7_s = instr[31:25];
  assign m_op_s   = (opcode_s == OPC_OP) && (funct7_s == 7'b0000001);
  // Only DIV/DIVU/REM/REMU (funct3[2]=1) take the long path; MUL* are single-cycle.
  assign div_s    = EN_M && m_op_s && funct3_s[2];

  // Combinational instruction decode into the control bundle.
  always_comb begin
    dec_s           = ctrl_reset();
    dec_s.rd        = instr[11:7];
    dec_s.rs1       = instr[19:15];
    dec_s.rs2       = instr[24:20];
    dec_s.str_ctrl  = funct3_s;
    dec_s.src_a_sel = 2'b11;
    dec_s.src_b_sel = 2'b00;
    case (opcode_s)
      OPC_LOAD: begin
        dec_s.reg_write  = 1'b1;
        dec_s.mem_to_reg = 1'b1;
        dec_s.src_b_sel  = 2'b01;
        dec_s.imm_sel    = 3'd5;
      end
      OPC_STORE: begin
        dec_s.mem_write = 1'b1;
        dec_s.src_b_sel = 2'b01;
        dec_s.imm_sel   = 3'd2;
      end
      OPC_OPIMM: begin
        dec_s.reg_write = 1'b1;
        dec_s.src_b_sel = 2'b01;
        dec_s.imm_sel   = 3'd0;
        // Shift-right immediates carry the arithmetic/logical choice in funct7[5].
        if (funct3_s == 3'b101) begin
          dec_s.alu_op = {1'b0, funct7_s[5], funct3_s};
        end else begin
          dec_s.alu_op = {2'b00, funct3_s};
        end
      end
      OPC_OP: begin
        if (m_op_s) begin
          if (EN_M) begin
            dec_s.reg_write = 1'b1;
            dec_s.alu_op    = {2'b10, funct3_s};
          end else begin
            dec_s.illegal = 1'b1;
          end
        end else begin
          dec_s.reg_write = 1'b1;
          dec_s.alu_op    = {1'b0, funct7_s[5], funct3_s};
        end
      end
      OPC_LUI: begin
        dec_s.reg_write = 1'b1;
        dec_s.src_a_sel = 2'b01;
        dec_s.src_b_sel = 2'b01;
        dec_s.imm_sel   = 3'd1;
      end
      OPC_AUIPC: begin
        dec_s.reg_write = 1'b1;
        dec_s.src_a_sel = 2'b00;
        dec_s.src_b_sel = 2'b01;
        dec_s.imm_sel   = 3'd1;
      end
      OPC_BRANCH: begin
        dec_s.pc_branch = 1'b1;
        dec_s.imm_sel   = 3'd3;
        dec_s.alu_op    = {2'b00, funct3_s};
      end
      OPC_JAL: begin
        dec_s.reg_write = 1'b1;
        dec_s.pc_branch = 1'b1;
        dec_s.src_a_sel = 2'b00;
        dec_s.src_b_sel = 2'b10;
        dec_s.imm_sel   = 3'd4;
        dec_s.alu_op    = 5'b01000;
      end
      OPC_JALR: begin
        dec_s.reg_write = 1'b1;
        dec_s.pc_branch = 1'b1;
        dec_s.jalr_n    = 1'b0;
        dec_s.src_a_sel = 2'b00;
        dec_s.src_b_sel = 2'b10;
        dec_s.imm_sel   = 3'd0;
        dec_s.alu_op    = 5'b01000;
      end
      default: begin
        dec_s.illegal = 1'b1;
      end
    endcase
  end

  // Upstream ready: slot empty, or full and draining this cycle.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_r)
      ST_EMPTY: in_ready_s = 1'b1;
      ST_FULL:  in_ready_s = out_ready;
      default:  in_ready_s = 1'b0;
    endcase
  end

  assign accept_s = in_valid && in_ready_s && !flush;

  // Next-state, divide countdown and bundle-load decision.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    load_s       = 1'b0;
    if (flush) begin
      state_next_s = ST_EMPTY;
      cnt_next_s   = '0;
    end else if (accept_s) begin
      // Accept happens from EMPTY or from a draining FULL (back-to-back reload).
      load_s = 1'b1;
      if (div_s) begin
        state_next_s = ST_MDWAIT;
        cnt_next_s   = CW'(MDIV_CYCLES - 1);
      end else begin
        state_next_s = ST_FULL;
        cnt_next_s   = '0;
      end
    end else begin
      case (state_r)
        ST_EMPTY: begin
          state_next_s = ST_EMPTY;
        end
        ST_FULL: begin
          if (out_ready) begin
            state_next_s = ST_EMPTY;
          end else begin
            state_next_s = ST_FULL;
          end
        end
        ST_MDWAIT: begin
          if (cnt_r == '0) begin
            state_next_s = ST_FULL;
          end else begin
            cnt_next_s = cnt_r - CW'(1);
          end
        end
        default: begin
          state_next_s = ST_EMPTY;
          cnt_next_s   = '0;
        end
      endcase
    end
  end

  // Pipeline slot registers: state, countdown, handshake flags and bundle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_EMPTY;
      cnt_r       <= '0;
      out_valid_r <= 1'b0;
      md_busy_r   <= 1'b0;
      ctrl_r      <= ctrl_reset();
      pc_r        <= '0;
    end else begin
      state_r     <= state_next_s;
      cnt_r       <= cnt_next_s;
      out_valid_r <= (state_next_s == ST_FULL);
      md_busy_r   <= (state_next_s == ST_MDWAIT);
      if (load_s) begin
        ctrl_r <= dec_s;
        pc_r   <= pc_in;
      end else begin
        ctrl_r <= ctrl_r;
        pc_r   <= pc_r;
      end
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_r;
  assign md_busy    = md_busy_r;
  assign pc_out     = pc_r;
  assign rd         = ctrl_r.rd;
  assign rs1        = ctrl_r.rs1;
  assign rs2        = ctrl_r.rs2;
  assign reg_write  = ctrl_r.reg_write;
  assign mem_write  = ctrl_r.mem_write;
  assign mem_to_reg = ctrl_r.mem_to_reg;
  assign pc_branch  = ctrl_r.pc_branch;
  assign jalr_n     = ctrl_r.jalr_n;
  assign src_a_sel  = ctrl_r.src_a_sel;
  assign src_b_sel  = ctrl_r.src_b_sel;
  assign alu_op     = ctrl_r.alu_op;
  assign imm_sel    = ctrl_r.imm_sel;
  assign str_ctrl   = ctrl_r.str_ctrl;
  assign illegal    = ctrl_r.illegal;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_ctrl_stage
// Self-checking bench for decode_ctrl_stage. A transaction-level model tracks
// whether the slot holds a presented bundle or a pending divide (as a count of
// remaining cycles), and a table decoder derives the expected bundle from the
// instruction encoding rules. A second instance with EN_M=0 covers M-op
// rejection.
// -----------------------------------------------------------------------------
module tb_decode_ctrl_stage;

  localparam int MDIV = 4;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       pc_branch;
    logic       jalr_n;
    logic [1:0] src_a_sel;
    logic [1:0] src_b_sel;
    logic [4:0] alu_op;
    logic [2:0] imm_sel;
    logic [2:0] str_ctrl;
    logic       illegal;
  } bundle_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] pc_out;
  logic [4:0]  rd, rs1, rs2;
  logic        reg_write, mem_write, mem_to_reg, pc_branch, jalr_n;
  logic [1:0]  src_a_sel, src_b_sel;
  logic [4:0]  alu_op;
  logic [2:0]  imm_sel, str_ctrl;
  logic        illegal, md_busy;

  logic        in_valid_nm;
  logic        in_ready_nm;
  logic        out_valid_nm;
  logic        out_ready_nm;
  logic [31:0] pc_out_nm;
  logic [4:0]  rd_nm, rs1_nm, rs2_nm;
  logic        reg_write_nm, mem_write_nm, mem_to_reg_nm, pc_branch_nm, jalr_n_nm;
  logic [1:0]  src_a_sel_nm, src_b_sel_nm;
  logic [4:0]  alu_op_nm;
  logic [2:0]  imm_sel_nm, str_ctrl_nm;
  logic        illegal_nm, md_busy_nm;

  bundle_t dut_b;
  bundle_t dut_b_nm;

  assign dut_b = {rd, rs1, rs2, reg_write, mem_write, mem_to_reg, pc_branch, jalr_n,
                  src_a_sel, src_b_sel, alu_op, imm_sel, str_ctrl, illegal};
  assign dut_b_nm = {rd_nm, rs1_nm, rs2_nm, reg_write_nm, mem_write_nm, mem_to_reg_nm,
                     pc_branch_nm, jalr_n_nm, src_a_sel_nm, src_b_sel_nm, alu_op_nm,
                     imm_sel_nm, str_ctrl_nm, illegal_nm};

  decode_ctrl_stage #(.XLEN(32), .EN_M(1'b1), .MDIV_CYCLES(MDIV)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc_in(pc_in), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .pc_out(pc_out), .rd(rd), .rs1(rs1), .rs2(rs2),
    .reg_write(reg_write), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .pc_branch(pc_branch), .jalr_n(jalr_n), .src_a_sel(src_a_sel),
    .src_b_sel(src_b_sel), .alu_op(alu_op), .imm_sel(imm_sel),
    .str_ctrl(str_ctrl), .illegal(illegal), .md_busy(md_busy)
  );

  decode_ctrl_stage #(.XLEN(32), .EN_M(1'b0), .MDIV_CYCLES(MDIV)) u_dut_nm (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_nm), .in_ready(in_ready_nm),
    .instr(instr), .pc_in(pc_in), .flush(flush), .out_valid(out_valid_nm),
    .out_ready(out_ready_nm), .pc_out(pc_out_nm), .rd(rd_nm), .rs1(rs1_nm),
    .rs2(rs2_nm), .reg_write(reg_write_nm), .mem_write(mem_write_nm),
    .mem_to_reg(mem_to_reg_nm), .pc_branch(pc_branch_nm), .jalr_n(jalr_n_nm),
    .src_a_sel(src_a_sel_nm), .src_b_sel(src_b_sel_nm), .alu_op(alu_op_nm),
    .imm_sel(imm_sel_nm), .str_ctrl(str_ctrl_nm), .illegal(illegal_nm),
    .md_busy(md_busy_nm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model of the slot: presented bundle flag, remaining divide cycles, contents.
  bit          m_valid;
  int          m_wait;
  bundle_t     m_b;
  logic [31:0] m_pc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic bundle_t reset_bundle();
    bundle_t b;
    b         = '0;
    b.jalr_n  = 1'b1;
    b.imm_sel = 3'd6;
    return b;
  endfunction

  // Expected bundle straight from the encoding rules.
  function automatic bundle_t ref_decode(input logic [31:0] w, input bit en_m);
    bundle_t b;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = w[14:12];
    f7 = w[31:25];
    b = reset_bundle();
    b.rd = w[11:7]; b.rs1 = w[19:15]; b.rs2 = w[24:20];
    b.str_ctrl = f3; b.src_a_sel = 2'b11; b.src_b_sel = 2'b00;
    case (w[6:0])
      OPC_LOAD:   begin b.reg_write = 1; b.mem_to_reg = 1; b.src_b_sel = 2'b01; b.imm_sel = 3'd5; end
      OPC_STORE:  begin b.mem_write = 1; b.src_b_sel = 2'b01; b.imm_sel = 3'd2; end
      OPC_OPIMM:  begin
        b.reg_write = 1; b.src_b_sel = 2'b01; b.imm_sel = 3'd0;
        b.alu_op = (f3 == 3'b101) ? {1'b0, f7[5], f3} : {2'b00, f3};
      end
      OPC_OP: begin
        if (f7 == 7'b0000001 && !en_m) b.illegal = 1;
        else if (f7 == 7'b0000001) begin b.reg_write = 1; b.alu_op = {2'b10, f3}; end
        else begin b.reg_write = 1; b.alu_op = {1'b0, f7[5], f3}; end
      end
      OPC_LUI:    begin b.reg_write = 1; b.src_a_sel = 2'b01; b.src_b_sel = 2'b01; b.imm_sel = 3'd1; end
      OPC_AUIPC:  begin b.reg_write = 1; b.src_a_sel = 2'b00; b.src_b_sel = 2'b01; b.imm_sel = 3'd1; end
      OPC_BRANCH: begin b.pc_branch = 1; b.imm_sel = 3'd3; b.alu_op = {2'b00, f3}; end
      OPC_JAL:    begin b.reg_write = 1; b.pc_branch = 1; b.src_a_sel = 2'b00; b.src_b_sel = 2'b10;
                        b.imm_sel = 3'd4; b.alu_op = 5'b01000; end
      OPC_JALR:   begin b.reg_write = 1; b.pc_branch = 1; b.jalr_n = 0; b.src_a_sel = 2'b00;
                        b.src_b_sel = 2'b10; b.imm_sel = 3'd0; b.alu_op = 5'b01000; end
      default:    b.illegal = 1;
    endcase
    return b;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int sel;
    w = $urandom;
    sel = $urandom_range(0, 11);
    case (sel)
      0: w[6:0] = OPC_LOAD;
      1: w[6:0] = OPC_STORE;
      2: w[6:0] = OPC_OPIMM;
      3: w[6:0] = OPC_OP;
      4: w[6:0] = OPC_LUI;
      5: w[6:0] = OPC_AUIPC;
      6: w[6:0] = OPC_BRANCH;
      7: w[6:0] = OPC_JAL;
      8: w[6:0] = OPC_JALR;
      9: begin w[6:0] = OPC_OP; w[31:25] = 7'b0000001; end
      10: begin w[6:0] = OPC_OP; w[31:25] = 7'b0000001; w[14] = 1'b1; end
      default: w[6:0] = w[31] ? 7'h7F : 7'h0F;
    endcase
    return w;
  endfunction

  // One clock cycle: drive at negedge, check ready, advance model at posedge, check outputs.
  task automatic step(input logic iv, input logic [31:0] ins, input logic fl, input logic ordy);
    bit exp_rdy;
    bit acc;
    bit is_div;
    logic [31:0] pcv;
    @(negedge clk);
    pcv = $urandom;
    in_valid = iv; instr = ins; pc_in = pcv; flush = fl; out_ready = ordy;
    #1;
    exp_rdy = !(m_valid || m_wait > 0) || (m_valid && ordy);
    check_eq("in_ready", 64'(in_ready), 64'(exp_rdy));
    acc = iv && exp_rdy && !fl;
    is_div = (ins[6:0] == OPC_OP) && (ins[31:25] == 7'b0000001) && ins[14];
    @(posedge clk);
    if (fl) begin
      m_valid = 0; m_wait = 0;
    end else if (acc) begin
      m_b = ref_decode(ins, 1'b1);
      m_pc = pcv;
      if (is_div) begin m_valid = 0; m_wait = MDIV; end
      else m_valid = 1;
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) m_valid = 1;
    end else if (m_valid && ordy) begin
      m_valid = 0;
    end
    #1;
    check_eq("out_valid", 64'(out_valid), 64'(m_valid));
    check_eq("md_busy", 64'(md_busy), 64'(m_wait > 0));
    if (m_valid) begin
      check_eq("bundle", 64'(dut_b), 64'(m_b));
      check_eq("pc_out", 64'(pc_out), 64'(m_pc));
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; instr = 32'h0; pc_in = 32'h0; flush = 1'b0;
    out_ready = 1'b0; in_valid_nm = 1'b0; out_ready_nm = 1'b1;
    m_valid = 0; m_wait = 0; m_b = reset_bundle(); m_pc = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'(1'b0));
    check_eq("rst_md_busy", 64'(md_busy), 64'(1'b0));
    check_eq("rst_bundle", 64'(dut_b), 64'(reset_bundle()));
    check_eq("rst_pc_out", 64'(pc_out), 64'(32'h0));
    check_eq("rst_in_ready", 64'(in_ready), 64'(1'b1));
    @(negedge clk);
    rst_n = 1'b1;

    // ADD x3,x1,x2: one-cycle latency, R-type controls.
    step(1'b1, 32'h002081B3, 1'b0, 1'b1);
    check_eq("add_valid", 64'(out_valid), 64'(1'b1));
    check_eq("add_reg_write", 64'(reg_write), 64'(1'b1));
    check_eq("add_alu_op", 64'(alu_op), 64'(5'b00000));
    check_eq("add_src_b", 64'(src_b_sel), 64'(2'b00));
    // SRAI / SRLI share encoding except funct7[5].
    step(1'b1, 32'h4032D293, 1'b0, 1'b1);
    check_eq("srai_alu_op", 64'(alu_op), 64'(5'b01101));
    check_eq("srai_src_b", 64'(src_b_sel), 64'(2'b01));
    check_eq("srai_imm_sel", 64'(imm_sel), 64'(3'd0));
    step(1'b1, 32'h0032D293, 1'b0, 1'b1);
    check_eq("srli_alu_op", 64'(alu_op), 64'(5'b00101));
    step(1'b0, 32'h0, 1'b0, 1'b1);

    // DIV holds the slot for MDIV cycles while ADD waits upstream.
    step(1'b1, 32'h023140B3, 1'b0, 1'b1);
    check_eq("div_busy_0", 64'(md_busy), 64'(1'b1));
    for (int i = 1; i <= MDIV; i++) begin
      step(1'b1, 32'h002081B3, 1'b0, 1'b1);
      check_eq("div_out_valid", 64'(out_valid), 64'(i == MDIV));
    end
    check_eq("div_alu_op", 64'(alu_op), 64'(5'b10100));
    step(1'b0, 32'h0, 1'b0, 1'b1);

    // LW stalled by out_ready=0 for three cycles, then back-to-back reload.
    step(1'b1, 32'h0000A103, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'h002081B3, 1'b0, 1'b0);
      check_eq("lw_hold_rd", 64'(rd), 64'(5'd2));
    end
    step(1'b1, 32'h002081B3, 1'b0, 1'b1);
    check_eq("b2b_valid", 64'(out_valid), 64'(1'b1));
    check_eq("b2b_rd", 64'(rd), 64'(5'd3));
    step(1'b0, 32'h0, 1'b0, 1'b1);

    // Flush in the second MDWAIT cycle cancels the divide.
    step(1'b1, 32'h023140B3, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'h002081B3, 1'b1, 1'b1);
    check_eq("flush_md_busy", 64'(md_busy), 64'(1'b0));
    check_eq("flush_in_ready", 64'(in_ready), 64'(1'b1));
    for (int i = 0; i < MDIV + 2; i++) step(1'b0, 32'h0, 1'b0, 1'b1);

    // MUL rejected when M is disabled; unknown opcode flagged.
    in_valid_nm = 1'b1;
    step(1'b0, 32'h022081B3, 1'b0, 1'b1);
    in_valid_nm = 1'b0;
    check_eq("nm_out_valid", 64'(out_valid_nm), 64'(1'b1));
    check_eq("nm_illegal", 64'(illegal_nm), 64'(1'b1));
    check_eq("nm_reg_write", 64'(reg_write_nm), 64'(1'b0));
    check_eq("nm_bundle", 64'(dut_b_nm), 64'(ref_decode(32'h022081B3, 1'b0)));
    step(1'b1, 32'h0000007F, 1'b0, 1'b1);
    check_eq("bad_illegal", 64'(illegal), 64'(1'b1));
    check_eq("bad_imm_sel", 64'(imm_sel), 64'(3'd6));
    check_eq("bad_reg_write", 64'(reg_write), 64'(1'b0));
    step(1'b0, 32'h0, 1'b0, 1'b1);

    // Asynchronous reset mid-divide: immediate return to idle, no bundle later.
    step(1'b1, 32'h023140B3, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("arst_md_busy", 64'(md_busy), 64'(1'b0));
    check_eq("arst_out_valid", 64'(out_valid), 64'(1'b0));
    check_eq("arst_bundle", 64'(dut_b), 64'(reset_bundle()));
    m_valid = 0; m_wait = 0; m_b = reset_bundle();
    for (int i = 0; i < MDIV + 1; i++) begin
      @(posedge clk); #1;
      check_eq("arst_hold_valid", 64'(out_valid), 64'(1'b0));
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, rand_instr(), $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) < 7);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
